// File: rtl/binary_mul_9_1_bi.sv
// Fully pipelined 9x9 signed radix-2 multiplier, 17-bit product, 10-cycle latency.
// Stage 1 registers the operands; stages 2-10 each fold one multiplier bit, LSB first.
module binary_mul_9_1_bi (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               en,
   input  logic signed [8:0]  A,
   input  logic signed [8:0]  B,
   output logic signed [16:0] P
);

   // Multiplier bits are dropped once consumed, so stage k (1..9) only carries
   // B[8:k-1]. The shrinking slices are packed back to back in one vector.
   localparam int unsigned BPackBits = 45;

   function automatic int unsigned b_off(input int unsigned stage);
      return (stage - 1) * 10 - ((stage - 1) * stage) / 2;
   endfunction

   function automatic logic signed [17:0] part_prod(input logic signed [8:0] a,
                                                    input logic              b_bit,
                                                    input int unsigned       sh);
      logic signed [17:0] ext;
      ext = {{9{a[8]}}, a};
      return b_bit ? (ext <<< sh) : '0;
   endfunction

   logic signed [8:0]    a_q [1:9];
   logic signed [8:0]    a_d [1:9];
   logic [BPackBits-1:0] b_q;
   logic [BPackBits-1:0] b_d;
   logic signed [17:0]   s_q [2:9];
   logic signed [17:0]   s_d [2:9];
   logic signed [16:0]   p_q;
   logic signed [16:0]   p_d;

   always_comb begin
      a_d[1] = A;
      for (int unsigned k = 2; k <= 9; k++) begin
         a_d[k] = a_q[k-1];
      end

      b_d      = '0;
      b_d[8:0] = B;
      for (int unsigned k = 2; k <= 9; k++) begin
         for (int unsigned i = 0; i < 10 - k; i++) begin
            b_d[b_off(k) + i] = b_q[b_off(k - 1) + 1 + i];
         end
      end

      s_d[2] = part_prod(a_q[1], b_q[b_off(1)], 0);
      for (int unsigned s = 3; s <= 9; s++) begin
         s_d[s] = s_q[s-1] + part_prod(a_q[s-1], b_q[b_off(s - 1)], s - 2);
      end

      // B[8] carries weight -256, so its partial product is subtracted. Only this
      // final truncation can wrap (A = B = -256 gives 17'h10000).
      p_d = 17'(s_q[9] - part_prod(a_q[9], b_q[b_off(9)], 8));
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int unsigned k = 1; k <= 9; k++) begin
            a_q[k] <= '0;
         end
         b_q <= '0;
         for (int unsigned s = 2; s <= 9; s++) begin
            s_q[s] <= '0;
         end
         p_q <= '0;
      end else if (en) begin
         a_q <= a_d;
         b_q <= b_d;
         s_q <= s_d;
         p_q <= p_d;
      end
   end

   assign P = p_q;

endmodule

// File: tb/tb_binary_mul_9_1_bi.sv
// Bench for binary_mul_9_1_bi: a 10-deep delay line of exact products is compared to P
// every cycle, plus hand-computed directed expectations.
module tb_binary_mul_9_1_bi;

   logic        clk   = 1'b0;
   logic        rst_n = 1'b1;
   logic        en    = 1'b1;
   logic [8:0]  A     = '0;
   logic [8:0]  B     = '0;
   logic [16:0] P;

   int n_checks = 0;
   int n_pass   = 0;
   bit cmp_on   = 1'b0;

   logic [16:0] pipe [10];

   binary_mul_9_1_bi dut (
      .clk   (clk),
      .rst_n (rst_n),
      .en    (en),
      .A     (A),
      .B     (B),
      .P     (P)
   );

   always #5 clk = ~clk;

   function automatic logic [16:0] mul17(input logic [8:0] a, input logic [8:0] b);
      int x;
      x = int'($signed(a)) * int'($signed(b));
      return x[16:0];
   endfunction

   task automatic check(input string name, input int got, input int want);
      n_checks++;
      if (got == want) n_pass++;
      else $display("FAIL %s: got %0d, want %0d (t=%0t)", name, got, want, $time);
   endtask

   // Reference: each enabled edge pushes the exact product into a 10-entry delay line.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 10; i++) pipe[i] <= '0;
      end else if (en) begin
         pipe[0] <= mul17(A, B);
         for (int i = 1; i < 10; i++) pipe[i] <= pipe[i-1];
      end
   end

   always @(negedge clk) begin
      if (cmp_on) check("model", int'($signed(P)), int'($signed(pipe[9])));
   end

   task automatic hold(input int a, input int b);
      @(negedge clk);
      A = 9'(a);
      B = 9'(b);
      repeat (10) @(posedge clk);
      #1;
   endtask

   task automatic edge_check(input string name, input int want);
      @(posedge clk);
      #1 check(name, int'($signed(P)), want);
   endtask

   int da [8] = '{3, -1, -256, 0, 255, -256, 255, -256};
   int db [8] = '{-5, -1, 1, -256, 255, 255, -256, -256};
   int de [8] = '{-15, 1, -256, 0, 65025, -65280, -65280, -65536};

   initial begin
      A = 9'h0FF;
      B = 9'h0FF;
      #2 rst_n = 1'b0;
      cmp_on = 1'b1;
      for (int k = 0; k < 5; k++) begin
         #3 check("reset_hold", int'($signed(P)), 0);
      end
      @(negedge clk);
      rst_n = 1'b1;
      A = '0;
      B = '0;
      repeat (10) @(posedge clk);
      #1 check("reset_release", int'($signed(P)), 0);

      for (int i = 0; i < 8; i++) begin
         hold(da[i], db[i]);
         check($sformatf("directed %0d*%0d", da[i], db[i]), int'($signed(P)), de[i]);
      end

      // Latency: the old product must survive exactly 9 edges after the switch.
      hold(2, 3);
      check("latency_pre", int'($signed(P)), 6);
      @(negedge clk);
      A = 9'(7);
      B = 9'(-9);
      repeat (9) @(posedge clk);
      #1 check("latency_9", int'($signed(P)), 6);
      edge_check("latency_10", -63);

      // Streaming, then a 3-cycle stall while results are emerging.
      @(negedge clk); A = 9'(1);   B = 9'(1);
      @(negedge clk); A = 9'(2);   B = 9'(-2);
      @(negedge clk); A = 9'(-3);  B = 9'(3);
      @(negedge clk); A = 9'(100); B = 9'(-100);
      repeat (6) @(posedge clk);
      edge_check("stream_1", 1);
      edge_check("stream_2", -4);
      @(negedge clk) en = 1'b0;
      for (int k = 0; k < 3; k++) edge_check("stall_hold", -4);
      @(negedge clk) en = 1'b1;
      edge_check("stream_3", -9);
      edge_check("stream_4", -10000);

      // Reset mid-operation discards everything in flight.
      hold(-77, 55);
      @(negedge clk); A = 9'(11); B = 9'(12);
      @(posedge clk);
      #2 rst_n = 1'b0;
      #1 check("midreset", int'($signed(P)), 0);
      @(negedge clk);
      rst_n = 1'b1;
      A = 9'(9);
      B = 9'(9);
      repeat (9) @(posedge clk);
      #1 check("after_reset_9", int'($signed(P)), 0);
      edge_check("after_reset_10", 81);

      // Streamed sweep: every A value against 64 B values, rotated so all B patterns occur.
      for (int i = 0; i < 512; i++) begin
         for (int t = 0; t < 64; t++) begin
            @(negedge clk);
            A = 9'(i);
            B = 9'(8 * t + (i & 7));
         end
      end
      repeat (12) @(negedge clk);
      cmp_on = 1'b0;

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
